controle_unit: RTL and testbench



---
 rtl/controle_unit.sv | 182 ++++++++++++++++++
 tb/tb_controle_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/controle_unit.sv
// ============================================================================
// Module   : controle_unit
// Purpose  : MIPS-style main control decoder with registered control outputs
//            and combinational PC+4 / branch-target adders.
// Config   : CONTROLE_OVERFLOW_EN enables sinalMayCauseOverflow (else tied 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module controle_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] pc,
    input  logic [15:0] immediate,
    output logic        regDst,
    output logic        jump,
    output logic        memToReg,
    output logic        ALUsrc,
    output logic        regWrite,
    output logic        sinalMuxJal,
    output logic        sinalSll,
    output logic        sinalSrl,
    output logic        sinalZeroOrSign,
    output logic        sinalLui,
    output logic        sinalMayCauseOverflow,
    output logic        sinalDoControleLhu,
    output logic        sinalDoControleLbu,
    output logic        sinalJal,
    output logic        sinalJr,
    output logic [1:0]  branch,
    output logic [1:0]  memRead,
    output logic [1:0]  memWrite,
    output logic [3:0]  ALUop,
    output logic [31:0] pc_plus_4,
    output logic [31:0] branch_target
);

    localparam logic [3:0] C_ALU_AND  = 4'd0;
    localparam logic [3:0] C_ALU_OR   = 4'd1;
    localparam logic [3:0] C_ALU_ADD  = 4'd2;
    localparam logic [3:0] C_ALU_SUB  = 4'd6;
    localparam logic [3:0] C_ALU_SLT  = 4'd7;
    localparam logic [3:0] C_ALU_SLTU = 4'd8;
    localparam logic [3:0] C_ALU_NOR  = 4'd12;

`ifdef CONTROLE_OVERFLOW_EN
    localparam logic C_OVF_EN = 1'b1;
`else
    localparam logic C_OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic       reg_dst;
        logic       jump;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic       mux_jal;
        logic       sll;
        logic       srl;
        logic       zero_or_sign;
        logic       lui;
        logic       ovf;
        logic       lhu;
        logic       lbu;
        logic       jal;
        logic       jr;
        logic [1:0] branch;
        logic [1:0] mem_read;
        logic [1:0] mem_write;
        logic [3:0] alu_op;
    } ctrl_t;

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;
    logic  rtype_hit;

    always_comb begin
        ctrl_d    = '0;
        rtype_hit = 1'b0;
        case (opcode)
            6'h00: begin
                rtype_hit = 1'b1;
                case (funct)
                    6'h20: begin ctrl_d.alu_op = C_ALU_ADD;  ctrl_d.ovf = C_OVF_EN; end
                    6'h21: ctrl_d.alu_op = C_ALU_ADD;
                    6'h22: begin ctrl_d.alu_op = C_ALU_SUB;  ctrl_d.ovf = C_OVF_EN; end
                    6'h23: ctrl_d.alu_op = C_ALU_SUB;
                    6'h24: ctrl_d.alu_op = C_ALU_AND;
                    6'h25: ctrl_d.alu_op = C_ALU_OR;
                    6'h27: ctrl_d.alu_op = C_ALU_NOR;
                    6'h2A: ctrl_d.alu_op = C_ALU_SLT;
                    6'h2B: ctrl_d.alu_op = C_ALU_SLTU;
                    6'h00: ctrl_d.sll    = 1'b1;
                    6'h02: ctrl_d.srl    = 1'b1;
                    6'h08: begin rtype_hit = 1'b0; ctrl_d.jr = 1'b1; end
                    default: rtype_hit = 1'b0;
                endcase
                // jr and unknown funct fall out here with no register write.
                ctrl_d.reg_dst   = rtype_hit;
                ctrl_d.reg_write = rtype_hit;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                case (opcode)
                    6'h08: begin ctrl_d.alu_op = C_ALU_ADD; ctrl_d.ovf = C_OVF_EN; end
                    6'h09: ctrl_d.alu_op = C_ALU_ADD;
                    6'h0A: ctrl_d.alu_op = C_ALU_SLT;
                    6'h0B: ctrl_d.alu_op = C_ALU_SLTU;
                    6'h0C: begin ctrl_d.alu_op = C_ALU_AND; ctrl_d.zero_or_sign = 1'b1; end
                    default: begin ctrl_d.alu_op = C_ALU_OR; ctrl_d.zero_or_sign = 1'b1; end
                endcase
            end
            6'h0F: begin
                ctrl_d.lui       = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            6'h23, 6'h25, 6'h24: begin
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_op     = C_ALU_ADD;
                case (opcode)
                    6'h23: ctrl_d.mem_read = 2'b01;
                    6'h25: begin ctrl_d.mem_read = 2'b10; ctrl_d.lhu = 1'b1; end
                    default: begin ctrl_d.mem_read = 2'b11; ctrl_d.lbu = 1'b1; end
                endcase
            end
            6'h2B: begin ctrl_d.alu_src = 1'b1; ctrl_d.alu_op = C_ALU_ADD; ctrl_d.mem_write = 2'b01; end
            6'h29: begin ctrl_d.alu_src = 1'b1; ctrl_d.alu_op = C_ALU_ADD; ctrl_d.mem_write = 2'b10; end
            6'h28: begin ctrl_d.alu_src = 1'b1; ctrl_d.alu_op = C_ALU_ADD; ctrl_d.mem_write = 2'b11; end
            6'h04: begin ctrl_d.alu_op = C_ALU_SUB; ctrl_d.branch = 2'b01; end
            6'h05: begin ctrl_d.alu_op = C_ALU_SUB; ctrl_d.branch = 2'b10; end
            6'h02: ctrl_d.jump = 1'b1;
            6'h03: begin
                ctrl_d.jump      = 1'b1;
                ctrl_d.mux_jal   = 1'b1;
                ctrl_d.jal       = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign regDst                = ctrl_q.reg_dst;
    assign jump                  = ctrl_q.jump;
    assign memToReg              = ctrl_q.mem_to_reg;
    assign ALUsrc                = ctrl_q.alu_src;
    assign regWrite              = ctrl_q.reg_write;
    assign sinalMuxJal           = ctrl_q.mux_jal;
    assign sinalSll              = ctrl_q.sll;
    assign sinalSrl              = ctrl_q.srl;
    assign sinalZeroOrSign       = ctrl_q.zero_or_sign;
    assign sinalLui              = ctrl_q.lui;
    assign sinalMayCauseOverflow = ctrl_q.ovf;
    assign sinalDoControleLhu    = ctrl_q.lhu;
    assign sinalDoControleLbu    = ctrl_q.lbu;
    assign sinalJal              = ctrl_q.jal;
    assign sinalJr               = ctrl_q.jr;
    assign branch                = ctrl_q.branch;
    assign memRead               = ctrl_q.mem_read;
    assign memWrite              = ctrl_q.mem_write;
    assign ALUop                 = ctrl_q.alu_op;

    // Address arithmetic is purely combinational and ignores rst.
    assign pc_plus_4     = pc + 32'd4;
    assign branch_target = pc_plus_4 + {{14{immediate[15]}}, immediate, 2'b00};

endmodule

`default_nettype wire

// File: tb/tb_controle_unit.sv
// ============================================================================
// Module   : tb_controle_unit
// Purpose  : Scoreboard bench for controle_unit using directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controle_unit;

    localparam logic [24:0] RD    = 25'd1 << 24;
    localparam logic [24:0] JMP   = 25'd1 << 23;
    localparam logic [24:0] M2R   = 25'd1 << 22;
    localparam logic [24:0] ASRC  = 25'd1 << 21;
    localparam logic [24:0] RW    = 25'd1 << 20;
    localparam logic [24:0] MJAL  = 25'd1 << 19;
    localparam logic [24:0] SLL   = 25'd1 << 18;
    localparam logic [24:0] SRL   = 25'd1 << 17;
    localparam logic [24:0] ZOS   = 25'd1 << 16;
    localparam logic [24:0] LUI   = 25'd1 << 15;
`ifdef CONTROLE_OVERFLOW_EN
    localparam logic [24:0] OVF   = 25'd1 << 14;
`else
    localparam logic [24:0] OVF   = 25'd0;
`endif
    localparam logic [24:0] LHU   = 25'd1 << 13;
    localparam logic [24:0] LBU   = 25'd1 << 12;
    localparam logic [24:0] JAL   = 25'd1 << 11;
    localparam logic [24:0] JR    = 25'd1 << 10;
    localparam logic [24:0] BEQ   = 25'd1 << 8;
    localparam logic [24:0] BNE   = 25'd2 << 8;
    localparam logic [24:0] MR_W  = 25'd1 << 6;
    localparam logic [24:0] MR_H  = 25'd2 << 6;
    localparam logic [24:0] MR_B  = 25'd3 << 6;
    localparam logic [24:0] MW_W  = 25'd1 << 4;
    localparam logic [24:0] MW_H  = 25'd2 << 4;
    localparam logic [24:0] MW_B  = 25'd3 << 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode, funct;
    logic [31:0] pc;
    logic [15:0] immediate;
    logic        regDst, jump, memToReg, ALUsrc, regWrite, sinalMuxJal, sinalSll, sinalSrl;
    logic        sinalZeroOrSign, sinalLui, sinalMayCauseOverflow, sinalDoControleLhu;
    logic        sinalDoControleLbu, sinalJal, sinalJr;
    logic [1:0]  branch, memRead, memWrite;
    logic [3:0]  ALUop;
    logic [31:0] pc_plus_4, branch_target;

    typedef struct {
        logic [24:0] ctrl;
        logic [31:0] pcp4;
        logic [31:0] bt;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   issued = 0;

    always #5 clk = ~clk;

    controle_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .pc(pc), .immediate(immediate),
        .regDst(regDst), .jump(jump), .memToReg(memToReg), .ALUsrc(ALUsrc),
        .regWrite(regWrite), .sinalMuxJal(sinalMuxJal), .sinalSll(sinalSll),
        .sinalSrl(sinalSrl), .sinalZeroOrSign(sinalZeroOrSign), .sinalLui(sinalLui),
        .sinalMayCauseOverflow(sinalMayCauseOverflow),
        .sinalDoControleLhu(sinalDoControleLhu), .sinalDoControleLbu(sinalDoControleLbu),
        .sinalJal(sinalJal), .sinalJr(sinalJr), .branch(branch), .memRead(memRead),
        .memWrite(memWrite), .ALUop(ALUop), .pc_plus_4(pc_plus_4),
        .branch_target(branch_target)
    );

    logic [24:0] act_ctrl;
    assign act_ctrl = {regDst, jump, memToReg, ALUsrc, regWrite, sinalMuxJal, sinalSll,
                       sinalSrl, sinalZeroOrSign, sinalLui, sinalMayCauseOverflow,
                       sinalDoControleLhu, sinalDoControleLbu, sinalJal, sinalJr,
                       branch, memRead, memWrite, ALUop};

    task automatic apply(input logic r, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] p, input logic [15:0] imm,
                         input logic [24:0] ectrl, input logic [31:0] epcp4,
                         input logic [31:0] ebt);
        exp_t e;
        @(negedge clk);
        rst = r; opcode = op; funct = fn; pc = p; immediate = imm;
        e.ctrl = ectrl; e.pcp4 = epcp4; e.bt = ebt; e.id = issued;
        exp_q.push_back(e);
        issued++;
    endtask

    // Monitor: one registered result appears after every edge following a push.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (act_ctrl !== e.ctrl) begin
                    miscompares++;
                    $display("FAIL ctrl vec%0d: got %h expected %h", e.id, act_ctrl, e.ctrl);
                end
                if (pc_plus_4 !== e.pcp4) begin
                    miscompares++;
                    $display("FAIL pc_plus_4 vec%0d: got %h expected %h", e.id, pc_plus_4, e.pcp4);
                end
                if (branch_target !== e.bt) begin
                    miscompares++;
                    $display("FAIL branch_target vec%0d: got %h expected %h", e.id, branch_target, e.bt);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; opcode = '0; funct = '0; pc = '0; immediate = '0;
        // Reset dominates a valid lw.
        apply(1, 6'h23, 6'h00, 32'h100, 16'h0000, 25'd0, 32'h104, 32'h104);
        apply(0, 6'h00, 6'h20, 32'h100, 16'h0001, RD|RW|25'd2|OVF, 32'h104, 32'h108);
        apply(0, 6'h03, 6'h00, 32'h40, 16'h0000, JMP|JAL|MJAL|RW, 32'h44, 32'h44);
        apply(0, 6'h04, 6'h00, 32'h10, 16'hFFFF, BEQ|25'd6, 32'h14, 32'h10);
        apply(0, 6'h3F, 6'h00, 32'hFFFFFFFC, 16'h0000, 25'd0, 32'h0, 32'h0);
        apply(0, 6'h24, 6'h00, 32'h0, 16'h0010, ASRC|M2R|RW|LBU|MR_B|25'd2, 32'h4, 32'h44);
        apply(0, 6'h28, 6'h00, 32'h0, 16'h8000, ASRC|MW_B|25'd2, 32'h4, 32'hFFFE0004);
        apply(0, 6'h00, 6'h08, 32'h20, 16'h0000, JR, 32'h24, 32'h24);
        apply(0, 6'h00, 6'h21, 32'h0, 16'h0000, RD|RW|25'd2, 32'h4, 32'h4);
        apply(0, 6'h00, 6'h22, 32'h0, 16'h0000, RD|RW|25'd6|OVF, 32'h4, 32'h4);
        apply(0, 6'h00, 6'h23, 32'h0, 16'h0000, RD|RW|25'd6, 32'h4, 32'h4);
        apply(0, 6'h00, 6'h24, 32'h0, 16'h0000, RD|RW|25'd0, 32'h4, 32'h4);
        apply(0, 6'h00, 6'h25, 32'h0, 16'h0000, RD|RW|25'd1, 32'h4, 32'h4);
        apply(0, 6'h00, 6'h27, 32'h0, 16'h0000, RD|RW|25'd12, 32'h4, 32'h4);
        apply(0, 6'h00, 6'h2A, 32'h0, 16'h0000, RD|RW|25'd7, 32'h4, 32'h4);
        apply(0, 6'h00, 6'h2B, 32'h0, 16'h0000, RD|RW|25'd8, 32'h4, 32'h4);
        apply(0, 6'h00, 6'h00, 32'h0, 16'h0000, RD|RW|SLL, 32'h4, 32'h4);
        apply(0, 6'h00, 6'h02, 32'h0, 16'h0000, RD|RW|SRL, 32'h4, 32'h4);
        apply(0, 6'h00, 6'h3F, 32'h0, 16'h0000, 25'd0, 32'h4, 32'h4);
        apply(0, 6'h08, 6'h20, 32'h0, 16'h0000, ASRC|RW|25'd2|OVF, 32'h4, 32'h4);
        apply(0, 6'h09, 6'h20, 32'h0, 16'h0000, ASRC|RW|25'd2, 32'h4, 32'h4);
        apply(0, 6'h0A, 6'h00, 32'h0, 16'h0000, ASRC|RW|25'd7, 32'h4, 32'h4);
        apply(0, 6'h0B, 6'h00, 32'h0, 16'h0000, ASRC|RW|25'd8, 32'h4, 32'h4);
        apply(0, 6'h0C, 6'h00, 32'h0, 16'h0000, ASRC|RW|ZOS, 32'h4, 32'h4);
        apply(0, 6'h0D, 6'h00, 32'h0, 16'h0000, ASRC|RW|ZOS|25'd1, 32'h4, 32'h4);
        apply(0, 6'h0F, 6'h00, 32'h0, 16'h0000, LUI|RW, 32'h4, 32'h4);
        apply(0, 6'h23, 6'h00, 32'h0, 16'h0000, ASRC|M2R|RW|MR_W|25'd2, 32'h4, 32'h4);
        apply(0, 6'h25, 6'h00, 32'h0, 16'h0000, ASRC|M2R|RW|LHU|MR_H|25'd2, 32'h4, 32'h4);
        apply(0, 6'h2B, 6'h00, 32'h0, 16'h0000, ASRC|MW_W|25'd2, 32'h4, 32'h4);
        apply(0, 6'h29, 6'h00, 32'h0, 16'h0000, ASRC|MW_H|25'd2, 32'h4, 32'h4);
        apply(0, 6'h05, 6'h00, 32'h1000, 16'h0003, BNE|25'd6, 32'h1004, 32'h1010);
        apply(0, 6'h02, 6'h00, 32'h0, 16'h0000, JMP, 32'h4, 32'h4);
        // Mid-stream reset, then decoding resumes immediately.
        apply(1, 6'h00, 6'h20, 32'h0, 16'h0000, 25'd0, 32'h4, 32'h4);
        apply(0, 6'h0D, 6'h00, 32'h0, 16'h0000, ASRC|RW|ZOS|25'd1, 32'h4, 32'h4);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        if (vectors != issued) begin
            miscompares++;
            $display("FAIL count: got %0d checked expected %0d", vectors, issued);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
